// File: rtl/spi_master.sv
// Initiator side of the 40-bit SPI link: turns a local-bus Start into one
// {cmd, data} frame on SCK/CS/MOSI and captures 32 read bits from MISO.
module spi_master #(
    parameter int CLK_DIV = 4,
    parameter int CS_GAP  = 8
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        Start,
    input  logic        Write,
    input  logic [3:0]  Addr,
    input  logic [31:0] Wdata,
    output logic        Busy,
    output logic        Done,
    output logic [31:0] Rdata,
    output logic        SPI_CLK,
    output logic        SPI_CS,
    output logic        SPI_MOSI,
    input  logic        SPI_MISO
);

    localparam int CNT_MAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
    localparam int CW      = $clog2(CNT_MAX) + 1;
    localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(CS_GAP - 1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [5:0]    BITS     = 6'd40;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        HIGH  = 3'd2,
        LOW   = 3'd3,
        HOLD  = 3'd4,
        GAP   = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [5:0]    bit_q, bit_d;
    logic [39:0]   shreg_q, shreg_d;
    logic [31:0]   rx_q, rx_d;
    logic          wr_q, wr_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          sck_q, sck_d;
    logic          cs_q, cs_d;
    logic          mosi_q, mosi_d;
    logic          miso_meta_q, miso_sync_q;

    // MISO comes from another clock domain, so it passes two flops first.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            miso_meta_q <= 1'b0;
            miso_sync_q <= 1'b0;
        end else begin
            miso_meta_q <= SPI_MISO;
            miso_sync_q <= miso_meta_q;
        end
    end

    // State, datapath and pin registers.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            cnt_q   <= CNT_ZERO;
            bit_q   <= 6'd0;
            shreg_q <= 40'd0;
            rx_q    <= 32'd0;
            wr_q    <= 1'b0;
            rdata_q <= 32'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sck_q   <= 1'b0;
            cs_q    <= 1'b1;
            mosi_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            rx_q    <= rx_d;
            wr_q    <= wr_d;
            rdata_q <= rdata_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            sck_q   <= sck_d;
            cs_q    <= cs_d;
            mosi_q  <= mosi_d;
        end
    end

    // Next-state logic; pin values are derived from the next state so they
    // line up with the state register.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_ONE;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        rx_d    = rx_q;
        wr_d    = wr_q;
        rdata_d = rdata_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = CNT_ZERO;
                if (Start) begin
                    shreg_d = {Write, 3'b000, Addr, (Write ? Wdata : 32'd0)};
                    wr_d    = Write;
                    bit_d   = 6'd0;
                    rx_d    = 32'd0;
                    busy_d  = 1'b1;
                    state_d = SETUP;
                end else begin
                    state_d = IDLE;
                end
            end
            SETUP: begin
                if (cnt_q == DIV_LAST) begin
                    cnt_d   = CNT_ZERO;
                    state_d = HIGH;
                end else begin
                    state_d = SETUP;
                end
            end
            HIGH: begin
                if (cnt_q == DIV_LAST) begin
                    rx_d    = {rx_q[30:0], miso_sync_q};
                    bit_d   = bit_q + 6'd1;
                    cnt_d   = CNT_ZERO;
                    state_d = LOW;
                end else begin
                    state_d = HIGH;
                end
            end
            LOW: begin
                // The low half after the 40th rise is the trailing SCK low
                // before the CS hold time.
                if (cnt_q == CNT_ZERO) begin
                    shreg_d = {shreg_q[38:0], 1'b0};
                end else begin
                    shreg_d = shreg_q;
                end
                if (cnt_q == DIV_LAST) begin
                    cnt_d   = CNT_ZERO;
                    state_d = (bit_q == BITS) ? HOLD : HIGH;
                end else begin
                    state_d = LOW;
                end
            end
            HOLD: begin
                if (cnt_q == DIV_LAST) begin
                    cnt_d   = CNT_ZERO;
                    rdata_d = wr_q ? rdata_q : rx_q;
                    state_d = GAP;
                end else begin
                    state_d = HOLD;
                end
            end
            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = CNT_ZERO;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    state_d = GAP;
                end
            end
            default: begin
                cnt_d   = CNT_ZERO;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase

        sck_d  = (state_d == HIGH);
        cs_d   = (state_d == IDLE) || (state_d == GAP);
        mosi_d = cs_d ? 1'b0 : shreg_d[39];
    end

    assign Busy     = busy_q;
    assign Done     = done_q;
    assign Rdata    = rdata_q;
    assign SPI_CLK  = sck_q;
    assign SPI_CS   = cs_q;
    assign SPI_MOSI = mosi_q;

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master with a behavioural SPI slave and a scoreboard
// of expected frames/read data checked at every Done.
`timescale 1ns/1ps
module tb_spi_master;

    localparam int CLK_DIV = 4;
    localparam int CS_GAP  = 8;
    localparam int LAT     = 82 * CLK_DIV + CS_GAP;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        Start;
    logic        Write;
    logic [3:0]  Addr;
    logic [31:0] Wdata;
    logic        Busy;
    logic        Done;
    logic [31:0] Rdata;
    logic        SPI_CLK;
    logic        SPI_CS;
    logic        SPI_MOSI;
    logic        SPI_MISO;

    spi_master #(.CLK_DIV(CLK_DIV), .CS_GAP(CS_GAP)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Write(Write),
        .Addr(Addr), .Wdata(Wdata), .Busy(Busy), .Done(Done), .Rdata(Rdata),
        .SPI_CLK(SPI_CLK), .SPI_CS(SPI_CS), .SPI_MOSI(SPI_MOSI),
        .SPI_MISO(SPI_MISO)
    );

    always #5 Clk = ~Clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int done_cnt = 0;
    int cs_run = 0;
    int last_cs_hi = 0;

    typedef struct packed {
        logic [39:0] mosi;
        logic [31:0] rd;
    } exp_t;
    exp_t        exp_q[$];
    logic [39:0] got_frame_q[$];
    int          got_rises_q[$];

    // Slave model state
    logic [31:0] miso_ram [16];
    logic [31:0] mosi_ram [16];
    logic [39:0] s_frame = 40'd0;
    int          s_rises = 0;
    logic [31:0] s_rd = 32'd0;
    logic        s_miso = 1'b0;
    logic        loopback = 1'b0;
    logic        noise_en = 1'b0;
    logic        noise = 1'b0;

    assign SPI_MISO = noise_en ? noise : s_miso;

    always @(posedge Clk) cyc <= cyc + 1;

    // Monitors: Done pulses and CS-high run lengths
    always @(negedge Clk) begin
        if (Done) done_cnt <= done_cnt + 1;
        if (SPI_CS) begin
            cs_run <= cs_run + 1;
        end else begin
            if (cs_run != 0) last_cs_hi <= cs_run;
            cs_run <= 0;
        end
    end

    // Slave: shifts MOSI on SCK rise, logs the frame when CS rises
    always @(posedge SPI_CLK or posedge SPI_CS) begin
        if (SPI_CS) begin
            if (s_rises > 0) begin
                got_frame_q.push_back(s_frame);
                got_rises_q.push_back(s_rises);
                if (s_frame[39] && s_rises == 40) mosi_ram[s_frame[35:32]] <= s_frame[31:0];
            end
            s_rises <= 0;
            s_frame <= 40'd0;
        end else begin
            s_frame <= {s_frame[38:0], SPI_MOSI};
            s_rises <= s_rises + 1;
            if (s_rises == 7)
                s_rd <= loopback ? mosi_ram[{s_frame[2:0], SPI_MOSI}]
                                 : miso_ram[{s_frame[2:0], SPI_MOSI}];
        end
    end

    // Slave: presents read data on SCK fall, MSB first, after the command byte
    always @(negedge SPI_CLK) begin
        if (!SPI_CS && s_rises >= 8 && s_rises < 40) s_miso <= s_rd[39 - s_rises];
    end

    // Asynchronous MISO noise with random phase
    always begin
        #($urandom_range(7, 61) * 0.1);
        noise = ~noise;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        do begin
            @(negedge Clk);
            n++;
        end while (!Done && n < 3000);
        check("done_seen", 64'(Done), 64'd1);
    endtask

    task automatic score(input string tag);
        exp_t e;
        e = exp_q.pop_front();
        check({tag, "_frame_logged"}, 64'(got_frame_q.size() > 0), 64'd1);
        if (got_frame_q.size() > 0) begin
            check({tag, "_mosi"}, 64'(got_frame_q.pop_front()), 64'(e.mosi));
            check({tag, "_rises"}, 64'(got_rises_q.pop_front()), 64'd40);
        end
        check({tag, "_rdata"}, 64'(Rdata), 64'(e.rd));
    endtask

    task automatic do_frame(input string tag, input logic w, input logic [3:0] a,
                            input logic [31:0] d, input logic [31:0] exp_rd);
        exp_t e;
        int   t0;
        @(negedge Clk);
        Start = 1'b1; Write = w; Addr = a; Wdata = d;
        e.mosi = {w, 3'b000, a, (w ? d : 32'd0)};
        e.rd   = exp_rd;
        exp_q.push_back(e);
        @(negedge Clk);
        Start = 1'b0; Write = ~w; Addr = ~a; Wdata = ~d;
        t0 = cyc;
        check({tag, "_busy"}, 64'(Busy), 64'd1);
        wait_done();
        check({tag, "_latency"}, 64'(cyc - t0), 64'(LAT));
        score(tag);
        @(negedge Clk);
        check({tag, "_done_1cyc"}, 64'(Done), 64'd0);
        check({tag, "_idle"}, 64'({Busy, SPI_CS}), 64'b01);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int t0;
        int d0;
        exp_t e;
        for (int i = 0; i < 16; i++) miso_ram[i] = 32'h1111_0000 + 32'(i);
        miso_ram[3] = 32'h1234_5678;
        Reset_n = 1'b0; Start = 1'b0; Write = 1'b0; Addr = 4'd0; Wdata = 32'd0;
        repeat (3) @(negedge Clk);
        check("reset_pins", 64'({SPI_CS, SPI_CLK, SPI_MOSI, Busy, Done}), 64'b10000);
        check("reset_rdata", 64'(Rdata), 64'd0);
        Reset_n = 1'b1;
        repeat (2) @(negedge Clk);

        // Write, then read with a preloaded slave
        do_frame("wr5", 1'b1, 4'd5, 32'hDEAD_BEEF, 32'd0);
        do_frame("rd3", 1'b0, 4'd3, 32'hFFFF_FFFF, 32'h1234_5678);

        // Write then loopback read; Rdata untouched by the write
        do_frame("wr9", 1'b1, 4'd9, 32'hCAFE_F00D, 32'h1234_5678);
        check("slave_mosi_ram9", 64'(mosi_ram[9]), 64'hCAFE_F00D);
        loopback = 1'b1;
        do_frame("rd9_loop", 1'b0, 4'd9, 32'd0, 32'hCAFE_F00D);
        loopback = 1'b0;

        // Noisy MISO during a write
        noise_en = 1'b1;
        do_frame("wr_noise", 1'b1, 4'd0, 32'h0F0F_1234, 32'hCAFE_F00D);
        check("noise_no_x", 64'($isunknown({SPI_CS, SPI_CLK, SPI_MOSI, Busy, Done, Rdata})), 64'd0);
        noise_en = 1'b0;

        // Reset in the middle of a read at SCK rise 20
        @(negedge Clk);
        Start = 1'b1; Write = 1'b0; Addr = 4'd3;
        @(negedge Clk);
        Start = 1'b0;
        n = 0;
        while (s_rises < 20 && n < 2000) begin
            @(negedge Clk);
            n++;
        end
        check("rst_reach_rise20", 64'(s_rises), 64'd20);
        d0 = done_cnt;
        Reset_n = 1'b0;
        #1;
        check("rst_mid_pins", 64'({SPI_CS, SPI_CLK, Busy}), 64'b100);
        check("rst_mid_rdata", 64'(Rdata), 64'd0);
        repeat (3) @(negedge Clk);
        Reset_n = 1'b1;
        got_frame_q.delete();
        got_rises_q.delete();
        repeat (400) @(negedge Clk);
        check("rst_no_done", 64'(done_cnt - d0), 64'd0);
        check("rst_idle_busy", 64'(Busy), 64'd0);
        do_frame("rd3_after_rst", 1'b0, 4'd3, 32'd0, 32'h1234_5678);

        // Start held high: three back-to-back frames at Addr=15
        d0 = done_cnt;
        @(negedge Clk);
        Start = 1'b1; Write = 1'b1; Addr = 4'd15; Wdata = 32'hA5A5_0F0F;
        e.mosi = {1'b1, 3'b000, 4'd15, 32'hA5A5_0F0F};
        e.rd   = 32'h1234_5678;
        for (int i = 0; i < 3; i++) exp_q.push_back(e);
        @(negedge Clk);
        t0 = cyc;
        for (int f = 0; f < 3; f++) begin
            wait_done();
            if (f == 2) Start = 1'b0;
            check($sformatf("b2b%0d_latency", f), 64'(cyc - t0), 64'((f == 0) ? LAT : LAT + 1));
            t0 = cyc;
            score($sformatf("b2b%0d", f));
            if (f > 0) check($sformatf("b2b%0d_cs_gap", f), 64'(last_cs_hi >= CS_GAP + 1), 64'd1);
        end
        repeat (20) @(negedge Clk);
        check("b2b_done_count", 64'(done_cnt - d0), 64'd3);
        check("b2b_idle", 64'({Busy, SPI_CS}), 64'b01);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
